// File: rtl/cfg_cmd_sequencer.sv
// Telecommand framer: EB/addr/dhi/dlo/xor-checksum frames -> single-cycle config writes.
// Optional `CFG_ADDR_RANGE_CHK_EN rejects checksum-valid frames addressed outside 0x02..0x15.
module cfg_cmd_sequencer #(
   parameter logic [7:0]  HEADER      = 8'hEB,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
   parameter int unsigned WR_GAP      = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_valid_in,
   output logic        rx_ready_out,
   output logic        wr_out,
   output logic [7:0]  wr_addr_out,
   output logic [15:0] wr_data_out,
   output logic        busy_out,
   output logic [15:0] good_frame_cnt_out,
   output logic [7:0]  chk_err_cnt_out,
   output logic [7:0]  tout_err_cnt_out,
   output logic [1:0]  last_err_out
);

   typedef enum logic [2:0] {StIdle, StAddr, StDhi, StDlo, StChk, StWrite, StGap} state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
   logic [15:0] tout_q, tout_d, gap_q, gap_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic [15:0] good_q, good_d;
   logic [7:0]  chk_err_q, chk_err_d, tout_err_q, tout_err_d;
   logic [1:0]  last_err_q, last_err_d;
   logic        accept, in_frame;

   assign rx_ready_out       = (state_q != StWrite) && (state_q != StGap);
   assign accept             = rx_valid_in && rx_ready_out;
   assign in_frame           = (state_q == StAddr) || (state_q == StDhi) ||
                               (state_q == StDlo) || (state_q == StChk);
   assign wr_out             = (state_q == StWrite);
   assign busy_out           = (state_q != StIdle);
   assign wr_addr_out        = wr_addr_q;
   assign wr_data_out        = wr_data_q;
   assign good_frame_cnt_out = good_q;
   assign chk_err_cnt_out    = chk_err_q;
   assign tout_err_cnt_out   = tout_err_q;
   assign last_err_out       = last_err_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      dhi_d      = dhi_q;
      dlo_d      = dlo_q;
      tout_d     = 16'd0;
      gap_d      = gap_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      good_d     = good_q;
      chk_err_d  = chk_err_q;
      tout_err_d = tout_err_q;
      last_err_d = last_err_q;

      // An accepted byte beats a timeout landing on the same cycle.
      if (in_frame && !accept) begin
         if (tout_q == TIMEOUT_CYC - 16'd1) begin
            state_d    = StIdle;
            tout_err_d = (tout_err_q == 8'hFF) ? tout_err_q : tout_err_q + 8'd1;
            last_err_d = 2'b10;
         end else begin
            tout_d = tout_q + 16'd1;
         end
      end

      case (state_q)
         StIdle: if (accept && rx_data_in == HEADER) state_d = StAddr;
         StAddr: if (accept) begin
            addr_d  = rx_data_in;
            state_d = StDhi;
         end
         StDhi: if (accept) begin
            dhi_d   = rx_data_in;
            state_d = StDlo;
         end
         StDlo: if (accept) begin
            dlo_d   = rx_data_in;
            state_d = StChk;
         end
         StChk: if (accept) begin
            if (rx_data_in == (addr_q ^ dhi_q ^ dlo_q)) begin
`ifdef CFG_ADDR_RANGE_CHK_EN
               if (addr_q < 8'h02 || addr_q > 8'h15) begin
                  state_d    = StIdle;
                  last_err_d = 2'b11;
               end else begin
                  state_d   = StWrite;
                  wr_addr_d = addr_q;
                  wr_data_d = {dhi_q, dlo_q};
               end
`else
               state_d   = StWrite;
               wr_addr_d = addr_q;
               wr_data_d = {dhi_q, dlo_q};
`endif
            end else begin
               state_d    = StIdle;
               chk_err_d  = (chk_err_q == 8'hFF) ? chk_err_q : chk_err_q + 8'd1;
               last_err_d = 2'b01;
            end
         end
         StWrite: begin
            good_d  = good_q + 16'd1;
            gap_d   = 16'd0;
            state_d = (WR_GAP == 0) ? StIdle : StGap;
         end
         StGap: begin
            if (gap_q == 16'(WR_GAP - 1)) state_d = StIdle;
            else gap_d = gap_q + 16'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= StIdle;
         addr_q     <= 8'd0;
         dhi_q      <= 8'd0;
         dlo_q      <= 8'd0;
         tout_q     <= 16'd0;
         gap_q      <= 16'd0;
         wr_addr_q  <= 8'd0;
         wr_data_q  <= 16'd0;
         good_q     <= 16'd0;
         chk_err_q  <= 8'd0;
         tout_err_q <= 8'd0;
         last_err_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         dhi_q      <= dhi_d;
         dlo_q      <= dlo_d;
         tout_q     <= tout_d;
         gap_q      <= gap_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         good_q     <= good_d;
         chk_err_q  <= chk_err_d;
         tout_err_q <= tout_err_d;
         last_err_q <= last_err_d;
      end
   end

endmodule

// File: tb/tb_cfg_cmd_sequencer.sv
// Directed bench for cfg_cmd_sequencer; writes are checked against a scoreboard queue.
module tb_cfg_cmd_sequencer;

   localparam logic [15:0] TO  = 16'd100;
   localparam int unsigned GAP = 4;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready, wr, busy;
   logic [7:0]  wr_addr, chk_cnt, tout_cnt;
   logic [15:0] wr_data, good_cnt;
   logic [1:0]  last_err;

   typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;
   wr_t sb[$];
   int  vectors = 0, miscompares = 0;
   int  low_cnt;

   cfg_cmd_sequencer #(.HEADER(8'hEB), .TIMEOUT_CYC(TO), .WR_GAP(GAP)) dut (
      .clk_in(clk), .rst_in(rst_n), .rx_data_in(rx_data), .rx_valid_in(rx_valid),
      .rx_ready_out(rx_ready), .wr_out(wr), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
      .busy_out(busy), .good_frame_cnt_out(good_cnt), .chk_err_cnt_out(chk_cnt),
      .tout_err_cnt_out(tout_cnt), .last_err_out(last_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && wr === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_wr", 32'(wr), 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.a));
            check("wr_data", 32'(wr_data), 32'(e.d));
         end
      end
   end

   // Leaves the caller 1 time unit after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check("ready_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, dh, dl, ck, input bit exp_wr,
                             output int low);
      send_byte(8'hEB);
      send_byte(a);
      send_byte(dh);
      send_byte(dl);
      send_byte(ck);
      if (exp_wr) sb.push_back({a, dh, dl});
      @(negedge clk);
      check("wr_latency", 32'(wr), 32'(exp_wr));
      low = 0;
      for (int i = 0; i < 20 && !rx_ready; i++) begin
         low++;
         @(negedge clk);
      end
   endtask

   function automatic logic [7:0] cks(input logic [7:0] a, dh, dl);
      return a ^ dh ^ dl;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, 32'(rx_ready), 32'd1);
      check({tag, "_wr"}, 32'(wr), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_addr"}, 32'(wr_addr), 32'd0);
      check({tag, "_data"}, 32'(wr_data), 32'd0);
      check({tag, "_good"}, 32'(good_cnt), 32'd0);
      check({tag, "_chk"}, 32'(chk_cnt), 32'd0);
      check({tag, "_tout"}, 32'(tout_cnt), 32'd0);
      check({tag, "_lerr"}, 32'(last_err), 32'd0);
   endtask

   initial begin
      int exp_good;
      #12;
      check_reset_vals("rst");
      rst_n = 1'b1;

      // Good frame, ready low for write cycle plus guard gap.
      send_frame(8'h04, 8'h12, 8'h34, cks(8'h04, 8'h12, 8'h34), 1'b1, low_cnt);
      check("gap_ready_low", 32'(low_cnt), 32'(1 + GAP));
      check("good1", 32'(good_cnt), 32'd1);
      check("hold_addr", 32'(wr_addr), 32'h04);
      check("hold_data", 32'(wr_data), 32'h1234);
      check("idle_after_gap", 32'(busy), 32'd0);
      check("lerr_none", 32'(last_err), 32'd0);

      // 04^12^34 is 22, so a 26 checksum byte is an error.
      send_frame(8'h04, 8'h12, 8'h34, 8'h26, 1'b0, low_cnt);
      check("chk1", 32'(chk_cnt), 32'd1);
      check("lerr_chk", 32'(last_err), 32'd1);
      send_frame(8'h02, 8'h00, 8'h01, 8'h00, 1'b0, low_cnt);
      check("chk2", 32'(chk_cnt), 32'd2);
      send_frame(8'h02, 8'h00, 8'h01, 8'h03, 1'b1, low_cnt);
      check("good2", 32'(good_cnt), 32'd2);
      check("lerr_kept", 32'(last_err), 32'd1);

      // Junk ahead of a frame is dropped silently.
      send_byte(8'h00);
      send_byte(8'h55);
      check("junk_idle", 32'(busy), 32'd0);
      send_frame(8'h03, 8'h00, 8'h55, 8'h56, 1'b1, low_cnt);
      check("good3", 32'(good_cnt), 32'd3);
      check("chk_junk", 32'(chk_cnt), 32'd2);

      // Inter-byte timeout.
      send_byte(8'hEB);
      send_byte(8'h10);
      repeat (int'(TO) - 1) @(posedge clk);
      #1 check("tout_pre", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("tout_idle", 32'(busy), 32'd0);
      check("tout_cnt1", 32'(tout_cnt), 32'd1);
      check("lerr_tout", 32'(last_err), 32'd2);

      // Byte on the last allowed cycle is accepted instead of timing out.
      send_byte(8'hEB);
      send_byte(8'h10);
      repeat (int'(TO) - 1) @(posedge clk);
      send_byte(8'h00);
      check("tout_edge_busy", 32'(busy), 32'd1);
      check("tout_edge_cnt", 32'(tout_cnt), 32'd1);
      send_byte(8'h01);
      send_byte(cks(8'h10, 8'h00, 8'h01));
      sb.push_back({8'h10, 16'h0001});
      repeat (2 + GAP) @(negedge clk);
      check("good4", 32'(good_cnt), 32'd4);

      // Checksum error counter saturates.
      for (int i = 0; i < 256; i++) send_frame(8'h05, 8'(i), 8'h00, 8'(~i), 1'b0, low_cnt);
      check("chk_sat", 32'(chk_cnt), 32'd255);
      check("lerr_sat", 32'(last_err), 32'd1);

      exp_good = 4;
`ifdef CFG_ADDR_RANGE_CHK_EN
      send_frame(8'h20, 8'h00, 8'h01, 8'h21, 1'b0, low_cnt);
      check("range_lerr", 32'(last_err), 32'd3);
      check("range_chk", 32'(chk_cnt), 32'd255);
`else
      send_frame(8'h20, 8'h00, 8'h01, 8'h21, 1'b1, low_cnt);
      check("range_lerr", 32'(last_err), 32'd1);
      exp_good = 5;
`endif
      check("good_range", 32'(good_cnt), 32'(exp_good));

      // Reset mid-frame discards the partial frame.
      send_byte(8'hEB);
      send_byte(8'h04);
      send_byte(8'h12);
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_wr", 32'(wr), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
